vme_cycle_ctrl: RTL and testbench
=================================

// Module: vme_cycle_ctrl
// PURPOSE
//  VME slave data-transfer handshake for the EA4163 A16/D16 register window.
//  Sits downstream of the address latch/decoder: consumes its window-hit and register-exists flags,
//  sequences the cycle, issues one-cycle read/write strobes to the register file, drives DTACK/BERR.
//  Owns the board's O_VME_DTACK_D / O_VME_DTACK_EN pins and the data-buffer enables.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth on AS, DS0, DS1, WR (>=2)
//  DTACK_DLY    3   clocks from strobe pulse to DTACK assertion (1..15); data-setup margin
//  NEG_CYCLES   1   clocks DTACK is actively driven high before release (active negation)
// PORTS
//  I_CLK_32M       in   1  system clock, 32 MHz
//  I_VME_SYSRESET  in   1  async active-high reset
//  I_VME_AS        in   1  VME address strobe, active low, async
//  I_VME_DS0       in   1  data strobe 0, active low, async
//  I_VME_DS1       in   1  data strobe 1, active low, async
//  I_VME_WR        in   1  VME WRITE line: 1 = read cycle, 0 = write cycle
//  I_VME_AM        in   6  address modifier, sampled in DECODE
//  I_SPACE_HIT     in   1  decoder: latched address inside 0x7Cxx window
//  I_REG_EXIST     in   1  decoder: latched address is an implemented register
//  O_VME_DTACK_D   out  1  DTACK level; 0 = acknowledge
//  O_VME_DTACK_EN  out  1  DTACK driver enable
//  O_VME_BERR      out  1  bus error, active high here (external inverting open-collector driver)
//  O_RD_STB        out  1  one-clock pulse: capture read data into output latch
//  O_WR_STB        out  1  one-clock pulse: write VME data into addressed register
//  O_RD_BUF_EN     out  1  enable board->VME data transceiver
//  O_WR_BUF_EN     out  1  enable VME->board data transceiver
//  O_BUSY          out  1  1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state IDLE, DTACK_D=1, DTACK_EN=0, BERR=0, strobes 0, buffer enables 0, BUSY=0.
//  Inputs synchronised SYNC_STAGES deep; "strobe" = sync AS=0 & DS0=0 & DS1=0 (D16 only).
//  "released" = sync DS0=1 & DS1=1. WR is sampled once, at IDLE->DECODE, and held for the cycle.
//  FSM:
//   IDLE    : strobe -> DECODE.
//   DECODE  : one clock for the decoder latches to settle.
//             AM in {0x29,0x2D} & SPACE_HIT & REG_EXIST -> ACCESS; AM ok & SPACE_HIT & !REG_EXIST -> ERROR;
//             else -> IGNORE. DECODE tests strobe first: strobe lost -> IDLE.
//   ACCESS  : entry clock pulses O_WR_STB (write) or O_RD_STB (read), exactly once per cycle;
//             RD_BUF_EN (read) / WR_BUF_EN (write) high from entry through ACK;
//             counter runs DTACK_DLY clocks -> ACK. Strobe lost before ACK -> IDLE, no DTACK, buffers off.
//   ACK     : DTACK_EN=1, DTACK_D=0; hold until released -> NEGATE.
//   NEGATE  : DTACK_EN=1, DTACK_D=1 for NEG_CYCLES clocks, buffers off -> IDLE.
//   ERROR   : BERR=1, no strobes, no DTACK; hold until released -> IDLE (BERR drops on the same edge).
//   IGNORE  : silent; wait for released -> IDLE (foreign board's cycle).
//  A new strobe is accepted only from IDLE; back-to-back cycles need DS release in between.
//  AS rising while DS still low does not end the cycle; DS release ends it.
//  DTACK and BERR are mutually exclusive in every state.
//  Worst-case read latency DS-low->DTACK = SYNC_STAGES + 1 + DTACK_DLY clocks (6 at defaults, ~190 ns).
//  Reset mid-cycle: all outputs to reset values immediately; DTACK/BERR released at once.
// STRUCTURE
//  Shared package ea4163_pkg: state enum encoding, AM constants AM_A16_NP=6'h29, AM_A16_SUP=6'h2D,
//  window base 8'h7C. One sub-module: vme_sync (parameterised N-bit multi-stage synchroniser,
//  reset value 1 for the active-low strobes). FSM plus counter stay in this module.
// TESTING
//  1 Read of 0x7CA4, AM=0x29, DS low 20 clk -> one RD_STB in clk 3, DTACK_D=0 in clk 6, DTACK held to DS release,
//    then DTACK_D=1 for 1 clk, then EN=0.
//  2 Write of 0x7CA6, AM=0x2D -> exactly one WR_STB, WR_BUF_EN high through ACK, no RD_STB.
//  3 0x7CA8 (window hit, REG_EXIST=0) -> BERR=1 until DS release; no DTACK and no strobe.
//  4 AM=0x39 or window miss -> IGNORE: all outputs quiet for the whole cycle; BUSY=1 until release.
//  5 DS released in ACCESS clk 1 -> IDLE, no DTACK; write strobe already issued is not repeated.
//  6 Reset pulse during ACK -> DTACK_EN=0 asynchronously; next cycle after reset completes normally.

Source files
------------

// File: rtl/ea4163_pkg.sv
// Shared definitions for the EA4163 A16/D16 register window: FSM encoding,
// accepted address modifiers and the window base.
package ea4163_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_NEGATE = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  localparam logic [5:0] AM_A16_NP  = 6'h29;
  localparam logic [5:0] AM_A16_SUP = 6'h2D;
  localparam logic [7:0] WIN_BASE   = 8'h7C;

  // Counter wide enough for the largest DTACK delay / negation length (15).
  localparam int CNT_W = 4;

  function automatic logic am_is_a16(input logic [5:0] am);
    return (am == AM_A16_NP) || (am == AM_A16_SUP);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// N-bit multi-stage synchroniser for asynchronous VME control lines.
// Resets to RST_VAL so the active-low strobes come up deasserted.
module vme_sync #(
  parameter int           N       = 4,
  parameter int           STAGES  = 2,
  parameter logic [N-1:0] RST_VAL = {N{1'b1}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage_q [STAGES];

  // Shift chain; stage 0 is the only flop that sees the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/vme_cycle_ctrl.sv
// VME slave data-transfer handshake for the EA4163 A16/D16 register window:
// sequences the cycle, pulses register-file strobes, drives DTACK/BERR and buffer enables.
import ea4163_pkg::*;

module vme_cycle_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DTACK_DLY   = 3,
  parameter int NEG_CYCLES  = 1
) (
  input  logic       I_CLK_32M,
  input  logic       I_VME_SYSRESET,
  input  logic       I_VME_AS,
  input  logic       I_VME_DS0,
  input  logic       I_VME_DS1,
  input  logic       I_VME_WR,
  input  logic [5:0] I_VME_AM,
  input  logic       I_SPACE_HIT,
  input  logic       I_REG_EXIST,
  output logic       O_VME_DTACK_D,
  output logic       O_VME_DTACK_EN,
  output logic       O_VME_BERR,
  output logic       O_RD_STB,
  output logic       O_WR_STB,
  output logic       O_RD_BUF_EN,
  output logic       O_WR_BUF_EN,
  output logic       O_BUSY
);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DTACK_DLY - 1);
  localparam logic [CNT_W-1:0] NEG_LAST = CNT_W'(NEG_CYCLES - 1);

  logic [3:0]       sync_s;
  logic             as_s, ds0_s, ds1_s, wr_s;
  logic             strobe_s, released_s, ds_low_s, am_ok_s;
  logic             entry_s, data_phase_s;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_cyc_q, rd_cyc_d;
  logic             dtack_lvl_q, dtack_lvl_d;
  logic             dtack_en_q, dtack_en_d;
  logic             berr_q, berr_d;
  logic             rd_stb_q, rd_stb_d;
  logic             wr_stb_q, wr_stb_d;
  logic             rd_buf_q, rd_buf_d;
  logic             wr_buf_q, wr_buf_d;
  logic             busy_q, busy_d;

  vme_sync #(
    .N       (4),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (4'b1111)
  ) u_sync (
    .clk_i (I_CLK_32M),
    .rst_i (I_VME_SYSRESET),
    .d_i   ({I_VME_WR, I_VME_DS1, I_VME_DS0, I_VME_AS}),
    .q_o   (sync_s)
  );

  assign {wr_s, ds1_s, ds0_s, as_s} = sync_s;
  assign strobe_s   = ~as_s & ~ds0_s & ~ds1_s;
  assign released_s = ds0_s & ds1_s;
  // Once decoded, only the data strobes keep the cycle alive; AS may rise early.
  assign ds_low_s   = ~ds0_s & ~ds1_s;
  assign am_ok_s    = am_is_a16(I_VME_AM);

  // Cycle sequencing, delay/negation counter and WRITE-line capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cyc_d = rd_cyc_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe_s) begin
          state_d  = ST_DECODE;
          rd_cyc_d = wr_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!strobe_s) begin
          state_d = ST_IDLE;
        end else if (am_ok_s && I_SPACE_HIT && I_REG_EXIST) begin
          state_d = ST_ACCESS;
          cnt_d   = {CNT_W{1'b0}};
        end else if (am_ok_s && I_SPACE_HIT) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_IGNORE;
        end
      end
      ST_ACCESS: begin
        if (!ds_low_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DLY_LAST) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_ACK: begin
        if (released_s) begin
          state_d = ST_NEGATE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_NEGATE: begin
        if (cnt_q == NEG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_ERROR, ST_IGNORE: begin
        if (released_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming clock, derived from the next state so the pins are flops.
  always_comb begin
    entry_s      = (state_d == ST_ACCESS) && (state_q != ST_ACCESS);
    data_phase_s = (state_d == ST_ACCESS) || (state_d == ST_ACK);
    rd_stb_d     = entry_s & rd_cyc_q;
    wr_stb_d     = entry_s & ~rd_cyc_q;
    rd_buf_d     = data_phase_s & rd_cyc_q;
    wr_buf_d     = data_phase_s & ~rd_cyc_q;
    dtack_en_d   = (state_d == ST_ACK) || (state_d == ST_NEGATE);
    dtack_lvl_d  = (state_d != ST_ACK);
    berr_d       = (state_d == ST_ERROR);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers; reset releases DTACK/BERR immediately.
  always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
    if (I_VME_SYSRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rd_cyc_q    <= 1'b1;
      dtack_lvl_q <= 1'b1;
      dtack_en_q  <= 1'b0;
      berr_q      <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_buf_q    <= 1'b0;
      wr_buf_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_cyc_q    <= rd_cyc_d;
      dtack_lvl_q <= dtack_lvl_d;
      dtack_en_q  <= dtack_en_d;
      berr_q      <= berr_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      rd_buf_q    <= rd_buf_d;
      wr_buf_q    <= wr_buf_d;
      busy_q      <= busy_d;
    end
  end

  assign O_VME_DTACK_D  = dtack_lvl_q;
  assign O_VME_DTACK_EN = dtack_en_q;
  assign O_VME_BERR     = berr_q;
  assign O_RD_STB       = rd_stb_q;
  assign O_WR_STB       = wr_stb_q;
  assign O_RD_BUF_EN    = rd_buf_q;
  assign O_WR_BUF_EN    = wr_buf_q;
  assign O_BUSY         = busy_q;

endmodule

// File: tb/tb_vme_cycle_ctrl.sv
// Self-checking bench for vme_cycle_ctrl: timestamp-based cycle model checked every
// clock, directed scenarios with literal timing expectations, then random cycles.
module tb_vme_cycle_ctrl;

  localparam int S   = 2;
  localparam int DLY = 3;
  localparam int NEG = 1;
  localparam int M   = 16383;

  localparam int C_NONE = 0;
  localparam int C_DEC  = 1;
  localparam int C_ACC  = 2;
  localparam int C_ACK  = 3;
  localparam int C_NEG  = 4;
  localparam int C_ERR  = 5;
  localparam int C_IGN  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n = 1'b1, ds0 = 1'b1, ds1 = 1'b1, wr = 1'b1;
  logic [5:0] am = 6'h00;
  logic       hit = 1'b0, ex = 1'b0;
  logic       dtack_d, dtack_en, berr, rd_stb, wr_stb, rd_buf, wr_buf, busy;

  always #5 clk = ~clk;

  vme_cycle_ctrl #(.SYNC_STAGES(S), .DTACK_DLY(DLY), .NEG_CYCLES(NEG)) dut (
    .I_CLK_32M      (clk),
    .I_VME_SYSRESET (rst),
    .I_VME_AS       (as_n),
    .I_VME_DS0      (ds0),
    .I_VME_DS1      (ds1),
    .I_VME_WR       (wr),
    .I_VME_AM       (am),
    .I_SPACE_HIT    (hit),
    .I_REG_EXIST    (ex),
    .O_VME_DTACK_D  (dtack_d),
    .O_VME_DTACK_EN (dtack_en),
    .O_VME_BERR     (berr),
    .O_RD_STB       (rd_stb),
    .O_WR_STB       (wr_stb),
    .O_RD_BUF_EN    (rd_buf),
    .O_WR_BUF_EN    (wr_buf),
    .O_BUSY         (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // input history indexed by the edge that samples it
  logic [3:0] h_sig [0:M];
  logic [5:0] h_am  [0:M];
  logic       h_hit [0:M];
  logic       h_ex  [0:M];

  int   k = 0;
  int   m_cls = C_NONE, m_t0 = 0, m_ack_at = 0, m_idle_at = 0;
  logic m_rd = 1'b1;

  int   o_rd, o_wr, o_ack, o_en, o_neg, o_berr, o_busy, o_wbuf, o_first_rd, o_first_ack;
  int   k_ds = 0;
  logic prev_ds0 = 1'b1;

  task automatic clear_obs();
    o_rd = 0; o_wr = 0; o_ack = 0; o_en = 0; o_neg = 0; o_berr = 0; o_busy = 0; o_wbuf = 0;
    o_first_rd = -1; o_first_ack = -1;
  endtask

  // Model update after each edge, per-cycle compare, observation and input recording.
  initial begin
    logic [3:0] sv;
    logic       s_strobe, s_rel, s_dslow, a_ok;
    logic       e_busy, e_rdstb, e_wrstb, e_rdbuf, e_wrbuf, e_en, e_lvl, e_berr;
    clear_obs();
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0;
        m_cls = C_NONE;
      end else begin
        k++;
        sv       = (k - S >= 1) ? h_sig[(k - S) & M] : 4'b1111;
        s_strobe = ~sv[0] & ~sv[1] & ~sv[2];
        s_rel    = sv[1] & sv[2];
        s_dslow  = ~sv[1] & ~sv[2];
        a_ok     = (h_am[k & M] == 6'h29) || (h_am[k & M] == 6'h2D);
        case (m_cls)
          C_NONE: if (s_strobe) begin m_cls = C_DEC; m_t0 = k; m_rd = sv[3]; end
          C_DEC: begin
            if (!s_strobe) m_cls = C_NONE;
            else if (a_ok && h_hit[k & M] && h_ex[k & M]) begin m_cls = C_ACC; m_ack_at = k + DLY; end
            else if (a_ok && h_hit[k & M]) m_cls = C_ERR;
            else m_cls = C_IGN;
          end
          C_ACC: if (!s_dslow) m_cls = C_NONE; else if (k == m_ack_at) m_cls = C_ACK;
          C_ACK: if (s_rel) begin m_cls = C_NEG; m_idle_at = k + NEG; end
          C_NEG: if (k == m_idle_at) m_cls = C_NONE;
          default: if (s_rel) m_cls = C_NONE;
        endcase
      end
      e_busy  = (m_cls != C_NONE);
      e_rdstb = (m_cls == C_ACC) && (k == m_t0 + 1) && m_rd;
      e_wrstb = (m_cls == C_ACC) && (k == m_t0 + 1) && !m_rd;
      e_rdbuf = ((m_cls == C_ACC) || (m_cls == C_ACK)) && m_rd;
      e_wrbuf = ((m_cls == C_ACC) || (m_cls == C_ACK)) && !m_rd;
      e_en    = (m_cls == C_ACK) || (m_cls == C_NEG);
      e_lvl   = (m_cls != C_ACK);
      e_berr  = (m_cls == C_ERR);
      chk("busy",     busy,     e_busy);
      chk("rd_stb",   rd_stb,   e_rdstb);
      chk("wr_stb",   wr_stb,   e_wrstb);
      chk("rd_buf",   rd_buf,   e_rdbuf);
      chk("wr_buf",   wr_buf,   e_wrbuf);
      chk("dtack_en", dtack_en, e_en);
      chk("dtack_d",  dtack_d,  e_lvl);
      chk("berr",     berr,     e_berr);
      if (dtack_en && berr) chk("dtack_berr_excl", 1, 0);
      if (rd_stb) begin o_rd++; if (o_first_rd < 0) o_first_rd = k; end
      if (wr_stb) o_wr++;
      if (dtack_en) o_en++;
      if (dtack_en && !dtack_d) begin o_ack++; if (o_first_ack < 0) o_first_ack = k; end
      if (dtack_en && dtack_d) o_neg++;
      if (berr) o_berr++;
      if (busy) o_busy++;
      if (wr_buf) o_wbuf++;
      h_sig[(k + 1) & M] = {wr, ds1, ds0, as_n};
      h_am [(k + 1) & M] = am;
      h_hit[(k + 1) & M] = hit;
      h_ex [(k + 1) & M] = ex;
      if (!ds0 && prev_ds0) k_ds = k + 1;
      prev_ds0 = ds0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_cycle(input logic w, input logic [5:0] a, input logic h, input logic e,
                             input int ds_len, input int as_rise, input int gap);
    as_n = 1'b0; wr = w; am = a; hit = h; ex = e;
    tick(1);
    ds0 = 1'b0; ds1 = 1'b0;
    for (int i = 0; i < ds_len; i++) begin
      if (i == as_rise) as_n = 1'b1;
      tick(1);
    end
    ds0 = 1'b1; ds1 = 1'b1; as_n = 1'b1;
    tick(gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ra;
    int         sel;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    tick(2);
    chk("reset_dtack_d", dtack_d, 1);
    chk("reset_dtack_en", dtack_en, 0);
    chk("reset_busy", busy, 0);

    // read, DS low 20 clocks
    clear_obs();
    drive_cycle(1'b1, 6'h29, 1'b1, 1'b1, 20, 99, 8);
    chk("t1_rd_count", o_rd, 1);
    chk("t1_rd_clk", o_first_rd - k_ds, 3);
    chk("t1_ack_clk", o_first_ack - k_ds, 6);
    chk("t1_ack_cycles", o_ack, 16);
    chk("t1_neg_cycles", o_neg, 1);
    chk("t1_wr_count", o_wr, 0);

    // write, supervisory AM
    clear_obs();
    drive_cycle(1'b0, 6'h2D, 1'b1, 1'b1, 12, 99, 8);
    chk("t2_wr_count", o_wr, 1);
    chk("t2_rd_count", o_rd, 0);
    chk("t2_wbuf_cycles", o_wbuf, 11);

    // window hit, missing register
    clear_obs();
    drive_cycle(1'b1, 6'h29, 1'b1, 1'b0, 10, 99, 8);
    chk("t3_berr_cycles", o_berr, 9);
    chk("t3_dtack_cycles", o_en, 0);
    chk("t3_rd_count", o_rd, 0);

    // foreign AM, then window miss
    clear_obs();
    drive_cycle(1'b1, 6'h39, 1'b1, 1'b1, 10, 99, 8);
    chk("t4_busy_cycles", o_busy, 10);
    chk("t4_quiet", o_en + o_berr + o_rd + o_wr, 0);
    clear_obs();
    drive_cycle(1'b0, 6'h29, 1'b0, 1'b1, 10, 99, 8);
    chk("t4b_busy_cycles", o_busy, 10);
    chk("t4b_quiet", o_en + o_berr + o_rd + o_wr, 0);

    // DS released during the first ACCESS clock of a write
    clear_obs();
    drive_cycle(1'b0, 6'h29, 1'b1, 1'b1, 2, 99, 8);
    chk("t5_wr_count", o_wr, 1);
    chk("t5_dtack_cycles", o_en, 0);
    chk("t5_busy_cycles", o_busy, 2);

    // reset pulse while acknowledging
    clear_obs();
    as_n = 1'b0; wr = 1'b1; am = 6'h29; hit = 1'b1; ex = 1'b1;
    tick(1);
    ds0 = 1'b0; ds1 = 1'b0;
    tick(10);
    chk("t6_in_ack", dtack_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_en", dtack_en, 0);
    chk("t6_async_dtack_d", dtack_d, 1);
    chk("t6_async_busy", busy, 0);
    ds0 = 1'b1; ds1 = 1'b1; as_n = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    tick(2);
    clear_obs();
    drive_cycle(1'b1, 6'h29, 1'b1, 1'b1, 8, 99, 8);
    chk("t6_after_rd_count", o_rd, 1);
    chk("t6_after_ack_clk", o_first_ack - k_ds, 6);

    // random cycles
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      if (sel < 3) ra = 6'h29;
      else if (sel < 5) ra = 6'h2D;
      else if (sel == 5) ra = 6'h39;
      else ra = 6'($urandom_range(0, 63));
      drive_cycle(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 3) != 0), $urandom_range(1, 14),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : 99,
                  $urandom_range(0, 5));
    end
    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
